w_4823_fir: RTL and testbench

W_4823_FIR -- requirements
Module: w_4823_fir

---
 rtl/w_4823_fir.sv | 96 +++++++++
 tb/tb_w_4823_fir.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/w_4823_fir.sv
// rtl/w_4823_fir.sv - 64-tap direct-form FIR, one sequential MAC per tap, loadable Q2.15 coefficients
module w_4823_fir (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_slow,
    input  logic [15:0] din,
    input  logic        valid_in,
    input  logic [16:0] cin,
    input  logic [5:0]  caddr,
    input  logic        cload,
    output logic [15:0] dout,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t             state;
    logic               slow_q;
    logic               strobe;
    logic signed [16:0] cmem [64];
    logic signed [15:0] dline [64];
    logic [5:0]         head;
    logic [5:0]         tap;
    logic [5:0]         rd_idx;
    logic signed [32:0] c_ext;
    logic signed [32:0] x_ext;
    logic signed [32:0] prod;
    logic signed [39:0] prod_ext;
    logic signed [39:0] acc;
    logic signed [39:0] acc_next;
    logic signed [39:0] acc_shr;
    logic [15:0]        sat;

    assign strobe = (clk_slow & ~slow_q) | valid_in;

    // head is the slot of the newest sample, so tap k reads x[n-k] at head-k
    assign rd_idx   = head - tap;
    assign c_ext    = {{16{cmem[tap][16]}}, cmem[tap]};
    assign x_ext    = {{17{dline[rd_idx][15]}}, dline[rd_idx]};
    assign prod     = c_ext * x_ext;
    assign prod_ext = {{7{prod[32]}}, prod};
    assign acc_next = acc + prod_ext;
    assign acc_shr  = acc_next >>> 15;

    always_comb begin
        sat = acc_shr[15:0];
        if (acc_shr > 40'sd32767)
            sat = 16'h7fff;
        else if (acc_shr < -40'sd32768)
            sat = 16'h8000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dout   <= '0;
            valid  <= 1'b0;
            acc    <= '0;
            slow_q <= 1'b1;
            head   <= '0;
            tap    <= '0;
            for (int i = 0; i < 64; i++) begin
                dline[i] <= '0;
                cmem[i]  <= '0;
            end
        end else begin
            slow_q <= clk_slow;
            valid  <= 1'b0;
            if (cload)
                cmem[caddr] <= cin;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        dline[head + 6'd1] <= din;
                        head  <= head + 6'd1;
                        acc   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + 6'd1;
                    if (tap == 6'd63) begin
                        dout  <= sat;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w_4823_fir.sv
// tb/tb_w_4823_fir.sv - randomized self-checking bench for w_4823_fir against a sum-of-products model
module tb_w_4823_fir;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_slow;
    logic [15:0] din;
    logic        valid_in;
    logic [16:0] cin;
    logic [5:0]  caddr;
    logic        cload;
    logic [15:0] dout;
    logic        valid;

    int total = 0;
    int bad   = 0;
    int cm [64];
    int hist [$];

    always #5 clk = ~clk;

    w_4823_fir dut (
        .clk      (clk),
        .rst      (rst),
        .clk_slow (clk_slow),
        .din      (din),
        .valid_in (valid_in),
        .cin      (cin),
        .caddr    (caddr),
        .cload    (cload),
        .dout     (dout),
        .valid    (valid)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            din      = 16'($urandom);
            cin      = 17'($urandom);
            caddr    = 6'($urandom);
            cload    = 1'($urandom);
            valid_in = 1'($urandom);
            clk_slow = 1'($urandom);
            tick();
        end
        rst = 1'b0; cload = 1'b0; valid_in = 1'b0; clk_slow = 1'b0;
        foreach (cm[i]) cm[i] = 0;
        hist.delete();
    endtask

    task automatic load_coef(input int a, input int v);
        cload = 1'b1; caddr = 6'(a); cin = 17'(v);
        tick();
        cload = 1'b0;
        cm[a] = v;
    endtask

    // y = sat16(floor(sum(c_k * x[n-k]) / 2^15)) using the coefficient each tap saw
    function automatic longint model_y(input int cu [64]);
        longint s = 0;
        for (int k = 0; k < 64; k++)
            if (k < hist.size()) s += longint'(cu[k]) * longint'(hist[k]);
        s = s >>> 15;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // mode 0: valid_in, 1: clk_slow edge, 2: both. Optional busy strobe and coefficient write during MAC.
    task automatic run_sample(input string tag, input int d, input int mode,
                              input int drop_cyc, input int drop_d,
                              input int wr_cyc, input int wr_a, input int wr_v);
        int cu [64];
        int vcount = 0;
        din = 16'(d);
        valid_in = (mode != 1);
        clk_slow = (mode != 0);
        tick();
        valid_in = 1'b0;
        clk_slow = 1'b0;
        hist.push_front(d);
        if (hist.size() > 64) void'(hist.pop_back());
        for (int j = 1; j <= 64; j++) begin
            cu[j-1] = cm[j-1];
            if (j == drop_cyc) begin valid_in = 1'b1; din = 16'(drop_d); end
            if (j == wr_cyc) begin
                cload = 1'b1; caddr = 6'(wr_a); cin = 17'(wr_v); cm[wr_a] = wr_v;
            end
            if (valid) vcount++;
            tick();
            valid_in = 1'b0;
            cload = 1'b0;
        end
        check({tag, "_valid"}, valid, 1);
        check({tag, "_dout"}, $signed(dout), model_y(cu));
        tick();
        check({tag, "_valid_end"}, valid, 0);
        check({tag, "_no_early_valid"}, vcount, 0);
    endtask

    initial begin
        int vcount;
        rst = 1'b1; clk_slow = 1'b1; valid_in = 1'b0; cload = 1'b0;
        din = '0; cin = '0; caddr = '0;
        tick();
        check("reset_dout", $signed(dout), 0);
        check("reset_valid", valid, 0);
        din = 16'($urandom); valid_in = 1'b0; cload = 1'b1; cin = 17'($urandom);
        tick();
        cload = 1'b0;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 5) clk_slow = 1'b0;
            tick();
            if (valid) vcount++;
        end
        check("reset_no_strobe", vcount, 0);
        check("reset_dout_hold", $signed(dout), 0);
        foreach (cm[i]) cm[i] = 0;

        // passthrough via each strobe source
        load_coef(0, 32768);
        run_sample("pass100", 100, 0, 0, 0, 0, 0, 0);
        run_sample("pass200", 200, 1, 0, 0, 0, 0, 0);
        run_sample("pass_m300", -300, 2, 0, 0, 0, 0, 0);
        check("pass_last", $signed(dout), -300);

        do_reset(2);
        load_coef(1, 32768);
        run_sample("delay7", 7, 0, 0, 0, 0, 0, 0);
        check("delay_first", $signed(dout), 0);
        run_sample("delay9", 9, 1, 0, 0, 0, 0, 0);
        check("delay_second", $signed(dout), 7);

        do_reset(2);
        for (int k = 0; k < 64; k++) load_coef(k, 512);
        for (int i = 0; i < 64; i++) run_sample("avg_pos", 6400, i % 3, 0, 0, 0, 0, 0);
        check("avg_pos_final", $signed(dout), 6400);
        for (int i = 0; i < 64; i++) run_sample("avg_neg", -6400, i % 3, 0, 0, 0, 0, 0);
        check("avg_neg_final", $signed(dout), -6400);

        do_reset(2);
        for (int k = 0; k < 64; k++) load_coef(k, 65535);
        for (int i = 0; i < 64; i++) run_sample("sat_pos", 32767, 0, 0, 0, 0, 0, 0);
        check("sat_pos_final", $signed(dout), 32767);
        for (int i = 0; i < 64; i++) run_sample("sat_neg", -32768, 0, 0, 0, 0, 0, 0);
        check("sat_neg_final", $signed(dout), -32768);

        // busy strobe dropped, coefficient rewritten mid-MAC both before and after its tap
        do_reset(2);
        load_coef(0, 32768);
        load_coef(1, 16384);
        run_sample("busy", 1000, 0, 10, 5555, 1, 1, -16384);
        run_sample("busy_next", 40, 0, 0, 0, 40, 0, 8192);
        check("busy_next_dout", $signed(dout), 40 - 500);

        // reset mid-MAC aborts with no valid pulse
        do_reset(2);
        load_coef(0, 32768);
        valid_in = 1'b1; din = 16'd1234;
        tick();
        valid_in = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        foreach (cm[i]) cm[i] = 0;
        hist.delete();
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        check("abort_dout", $signed(dout), 0);
        run_sample("after_abort", 55, 0, 0, 0, 0, 0, 0);

        // random coefficients, samples, busy strobes and mid-MAC writes
        do_reset(3);
        for (int k = 0; k < 64; k++) load_coef(k, int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < 40; i++) begin
            int dc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 64)) : 0;
            int wc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 64)) : 0;
            run_sample("rand", int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 2)),
                       dc, int'($urandom_range(0, 65535)) - 32768,
                       wc, int'($urandom_range(0, 63)), int'($urandom_range(0, 4095)) - 2048);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
